// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

  localparam int N_DIGITS_DEF = 3;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] CORR_THRESH   = 4'd8;
  localparam logic [3:0] CORR_SUB      = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold 10**n - 1.
  function automatic int bin_w(int n);
    int p;
    int w;
    p = 1;
    w = 0;
    for (int i = 0; i < n; i++) p = p * 10;
    while ((1 << w) < p) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// One BCD digit correction step of reverse double-dabble.
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= CORR_THRESH) ? d - CORR_SUB : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one bit per clock.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int BIN_W    = bin_w(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic                  busy
);

  localparam int DW    = 4 * N_DIGITS;
  localparam int SR_W  = DW + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t            state;
  state_t            state_nxt;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   shifted;
  logic [SR_W-1:0]   sr_nxt;
  logic [DW-1:0]     corr;
  logic [N_DIGITS-1:0] bad;
  logic [CNT_W-1:0]  cnt;
  logic              any_bad;
  logic              last;
  logic              take_in;
  logic              take_out;

  assign shifted = sr >> 1;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
    bcd_digit_corr u_corr (
      .d (shifted[BIN_W+4*i +: 4]),
      .q (corr[4*i +: 4])
    );
    assign bad[i] = bcd_in[4*i +: 4] > BCD_MAX_DIGIT;
  end

  assign sr_nxt   = {corr, shifted[BIN_W-1:0]};
  assign any_bad  = |bad;
  assign last     = cnt == CNT_W'(BIN_W - 1);
  assign take_in  = in_valid & in_ready;
  assign take_out = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (take_in) state_nxt = any_bad ? DONE : CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (take_out) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      cnt     <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take_in) begin
            err <= any_bad;
            cnt <= '0;
            if (any_bad) begin
              sr      <= '0;
              bin_out <= '0;
            end else begin
              sr <= {bcd_in, {BIN_W{1'b0}}};
            end
          end
        end
        CONV: begin
          sr  <= sr_nxt;
          cnt <= cnt + 1'b1;
          if (last) bin_out <= sr_nxt[BIN_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
